// File: rtl/sfr_bus_arbiter.sv
// Two-master arbiter/sequencer for the SFR bus: core (A) and debug host (B).
// Each access runs IDLE -> BUS -> ACK with round-robin fairness and an A-side lock.
module sfr_bus_arbiter (
    input  logic        clk,
    input  logic        nreset,
    input  logic        a_req,
    input  logic [7:0]  a_addr,
    input  logic        a_r,
    input  logic [1:0]  a_w,
    input  logic [15:0] a_dwrite,
    input  logic        a_lock,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic [7:0]  b_addr,
    input  logic        b_r,
    input  logic [1:0]  b_w,
    input  logic [15:0] b_dwrite,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    input  logic        hold,
    output logic        sel,
    output logic [7:0]  addr,
    output logic        r,
    output logic [1:0]  w,
    output logic [15:0] dwrite,
    input  logic [15:0] sfr_data,
    output logic        gnt_b
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0] state;
    logic       last_b;
    logic       lock_flag;
    logic       any_req;
    logic       pick_b;

    // lock_flag is only ever set after an A grant, so it simply overrides the pointer
    always_comb begin
        any_req = a_req | b_req;
        if (a_req && b_req) begin
            pick_b = ~(last_b | lock_flag);
        end else begin
            pick_b = b_req;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            last_b    <= 1'b1;
            lock_flag <= 1'b0;
            sel       <= 1'b0;
            addr      <= 8'h00;
            r         <= 1'b0;
            w         <= 2'b00;
            dwrite    <= 16'h0000;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= 16'h0000;
            b_rdata   <= 16'h0000;
            gnt_b     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!hold && any_req) begin
                        state  <= ST_BUS;
                        sel    <= 1'b1;
                        gnt_b  <= pick_b;
                        last_b <= pick_b;
                        if (pick_b) begin
                            addr   <= b_addr;
                            r      <= b_r;
                            w      <= b_w;
                            dwrite <= b_dwrite;
                        end else begin
                            addr   <= a_addr;
                            r      <= a_r;
                            w      <= a_w;
                            dwrite <= a_dwrite;
                        end
                    end
                end
                ST_BUS: begin
                    // addr and dwrite are left alone so the SFR sees no glitch after the cycle
                    state <= ST_ACK;
                    sel   <= 1'b0;
                    r     <= 1'b0;
                    w     <= 2'b00;
                    if (gnt_b) begin
                        b_ack   <= 1'b1;
                        b_rdata <= r ? sfr_data : 16'h0000;
                    end else begin
                        a_ack   <= 1'b1;
                        a_rdata <= r ? sfr_data : 16'h0000;
                    end
                end
                ST_ACK: begin
                    state     <= ST_IDLE;
                    a_ack     <= 1'b0;
                    b_ack     <= 1'b0;
                    gnt_b     <= 1'b0;
                    lock_flag <= a_lock & ~gnt_b;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Directed self-checking bench for sfr_bus_arbiter with a small combinational SFR model.
module tb_sfr_bus_arbiter;

    logic        clk;
    logic        nreset;
    logic        a_req, a_r, a_lock;
    logic [7:0]  a_addr;
    logic [1:0]  a_w;
    logic [15:0] a_dwrite;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req, b_r;
    logic [7:0]  b_addr;
    logic [1:0]  b_w;
    logic [15:0] b_dwrite;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic        hold;
    logic        sel, r;
    logic [7:0]  addr;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] sfr_data;
    logic        gnt_b;

    int errorCount = 0;
    int checkCount = 0;

    sfr_bus_arbiter dut (
        .clk(clk), .nreset(nreset),
        .a_req(a_req), .a_addr(a_addr), .a_r(a_r), .a_w(a_w), .a_dwrite(a_dwrite),
        .a_lock(a_lock), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_r(b_r), .b_w(b_w), .b_dwrite(b_dwrite),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .hold(hold), .sel(sel), .addr(addr), .r(r), .w(w), .dwrite(dwrite),
        .sfr_data(sfr_data), .gnt_b(gnt_b)
    );

    // SFR model: address 0x16 reads 0xBEEF, anything else reads {0xA5, addr}
    assign sfr_data = (sel && r) ? ((addr == 8'h16) ? 16'hBEEF : {8'hA5, addr}) : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ar, input logic br, input logic lk, input logic hd);
        a_req  = ar;
        b_req  = br;
        a_lock = lk;
        hold   = hd;
    endtask

    task automatic doReset();
        nreset = 1'b0;
        #3;
        nreset = 1'b1;
        tick();
    endtask

    // Four back-to-back transactions with both ports requesting; order bit i = 1 means B wins tx i
    task automatic runStream(input string name, input logic [3:0] order, input bit dropLock);
        a_addr = 8'h01; a_r = 1'b1; a_w = 2'b00;
        b_addr = 8'h02; b_r = 1'b1; b_w = 2'b00;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dropLock && i == 2) a_lock = 1'b0;
            tick();
            checkOutput({name, "_sel"}, 32'(sel), 32'd1);
            checkOutput({name, "_gnt"}, 32'(gnt_b), 32'(order[i]));
            checkOutput({name, "_addr"}, 32'(addr), order[i] ? 32'h02 : 32'h01);
            tick();
            checkOutput({name, "_acks"}, 32'({a_ack, b_ack}), order[i] ? 32'b01 : 32'b10);
            checkOutput({name, "_rdata"}, 32'(order[i] ? b_rdata : a_rdata),
                        order[i] ? 32'hA502 : 32'hA501);
            if (i == 3) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            tick();
            checkOutput({name, "_idle"}, 32'({sel, a_ack, b_ack}), 32'd0);
        end
    endtask

    initial begin
        nreset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        a_addr = 8'h00; a_r = 1'b0; a_w = 2'b00; a_dwrite = 16'h0000;
        b_addr = 8'h00; b_r = 1'b0; b_w = 2'b00; b_dwrite = 16'h0000;
        #12;
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_bus", {8'(addr), 22'(0), r, 1'b0} | 32'(w) | 32'(dwrite), 32'd0);
        checkOutput("rst_acks", 32'({a_ack, b_ack, gnt_b}), 32'd0);
        checkOutput("rst_rdata", {a_rdata, b_rdata}, 32'd0);
        nreset = 1'b1;
        tick();

        // single write from A
        a_addr = 8'h00; a_w = 2'b11; a_dwrite = 16'h1234; a_r = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("wr_sel", 32'(sel), 32'd1);
        checkOutput("wr_addr", 32'(addr), 32'h00);
        checkOutput("wr_w", 32'(w), 32'b11);
        checkOutput("wr_dwrite", 32'(dwrite), 32'h1234);
        checkOutput("wr_ack_early", 32'({a_ack, b_ack}), 32'd0);
        tick();
        checkOutput("wr_sel_off", 32'({sel, w}), 32'd0);
        checkOutput("wr_acks", 32'({a_ack, b_ack}), 32'b10);
        checkOutput("wr_rdata", 32'(a_rdata), 32'h0000);
        a_req = 1'b0;
        tick();
        checkOutput("wr_ack_clr", 32'({a_ack, b_ack}), 32'd0);

        // single read from B
        b_addr = 8'h16; b_r = 1'b1; b_w = 2'b00;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("rd_sel_r", 32'({sel, r}), 32'b11);
        checkOutput("rd_gnt_bus", 32'(gnt_b), 32'd1);
        tick();
        checkOutput("rd_acks", 32'({a_ack, b_ack}), 32'b01);
        checkOutput("rd_rdata", 32'(b_rdata), 32'hBEEF);
        checkOutput("rd_gnt_ack", 32'(gnt_b), 32'd1);
        checkOutput("rd_a_rdata_kept", 32'(a_rdata), 32'h0000);
        b_req = 1'b0;
        tick();
        checkOutput("rd_gnt_clr", 32'({gnt_b, b_ack}), 32'd0);

        // contention from reset: A,B,A,B
        doReset();
        runStream("cont", 4'b1010, 1'b0);

        // lock: A three times, then B once a_lock drops
        a_lock = 1'b1;
        runStream("lock", 4'b1000, 1'b1);

        // hold blocks new grants
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        a_addr = 8'h01; b_addr = 8'h02;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_block", 32'({sel, a_ack, b_ack}), 32'd0);
        end
        b_req = 1'b0;
        hold = 1'b0;
        tick();
        checkOutput("hold_release_sel", 32'(sel), 32'd1);
        checkOutput("hold_release_gnt", 32'(gnt_b), 32'd0);

        // asynchronous reset in the middle of BUS
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("mid_rst_sel", 32'(sel), 32'd0);
        checkOutput("mid_rst_acks", 32'({a_ack, b_ack, gnt_b}), 32'd0);
        checkOutput("mid_rst_rdata", {a_rdata, b_rdata}, 32'd0);
        #1;
        nreset = 1'b1;
        tick();
        checkOutput("post_rst_sel", 32'(sel), 32'd1);
        checkOutput("post_rst_addr", 32'({gnt_b, addr}), 32'h001);
        tick();
        checkOutput("post_rst_acks", 32'({a_ack, b_ack}), 32'b10);
        checkOutput("post_rst_rdata", 32'(a_rdata), 32'hA501);
        a_req = 1'b0;
        tick();
        checkOutput("post_rst_idle", 32'({sel, a_ack, b_ack}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
